hex_seg_driver: RTL

//   Downstream stage of each HEX PIO: takes the 7-bit segment pattern from the PIO out_port and drives one
//   7-segment digit pin group. Adds PWM dimming, blink, blanking, tear-free frame-boundary updates and

---
 rtl/hex_seg_pkg.sv | 21 ++
 rtl/hex_seg_prescaler.sv | 28 ++
 rtl/hex_seg_driver.sv | 108 ++++++++++
 3 files changed

// File: rtl/hex_seg_pkg.sv
// Shared types and helpers for the HEX digit driver: blink FSM states,
// off-patterns for both pin polarities and the blink half-period calculation.
package hex_seg_pkg;

   typedef enum logic [1:0] {
      ST_STEADY = 2'd0,
      ST_ON     = 2'd1,
      ST_OFF    = 2'd2
   } blink_state_t;

   localparam logic [6:0] SEG_OFF_LO = 7'h7F;
   localparam logic [6:0] SEG_OFF_HI = 7'h00;

   // Cycles per blink half-period, never less than one.
   function automatic int half_period(input int clk_hz, input int blink_hz);
      int hp;
      hp = clk_hz / (2 * blink_hz);
      return (hp < 1) ? 1 : hp;
   endfunction

endpackage

// File: rtl/hex_seg_prescaler.sv
// Blink prescaler: counts 0..HALF_PERIOD-1, pulses tc on the terminal count
// and reloads 0; clear holds the count at 0.
module hex_seg_prescaler #(
   parameter int HALF_PERIOD = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tc
);

   localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_PERIOD - 1);

   logic [CNT_W-1:0] cnt;

   assign tc = (cnt == TERM);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (clear || tc)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/hex_seg_driver.sv
// One 7-segment digit driver: PWM dimming, blink, blanking, frame-aligned pattern updates
// and pin polarity. Optional lamp test input enabled by HEX_SEG_LAMP_TEST_EN.
module hex_seg_driver
   import hex_seg_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BLINK_HZ   = 2,
   parameter int PWM_BITS   = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [6:0]          seg_in,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                blink_en,
   input  logic                blank,
`ifdef HEX_SEG_LAMP_TEST_EN
   input  logic                lamp_test,
`endif
   output logic [6:0]          hex_out,
   output logic                frame_tick
);

   localparam int                  HP      = half_period(CLK_HZ, BLINK_HZ);
   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
   localparam logic [6:0]          SEG_OFF = (ACTIVE_LOW != 0) ? SEG_OFF_LO : SEG_OFF_HI;

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] bri_sh;
   logic [6:0]          seg_sh;
   logic                frame_end;
   logic                pwm_on;
   logic                pre_tc;
   logic                blink_on;
   logic [6:0]          lit_p0;
   blink_state_t        state, state_nxt;

   assign frame_end = (pwm_cnt == PWM_MAX);
   assign pwm_on    = (bri_sh == PWM_MAX) | (pwm_cnt < bri_sh);

   // Shadow registers only change at the frame boundary so a frame never tears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt    <= '0;
         frame_tick <= 1'b0;
         seg_sh     <= '0;
         bri_sh     <= '0;
      end else begin
         pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
         frame_tick <= frame_end;
         if (frame_end) begin
            seg_sh <= seg_in;
            bri_sh <= brightness;
         end
      end
   end

   hex_seg_prescaler #(
      .HALF_PERIOD (HP)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state == ST_STEADY),
      .tc      (pre_tc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= ST_STEADY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      blink_on  = 1'b1;
      case (state)
         ST_STEADY: if (blink_en) state_nxt = ST_ON;
         ST_ON: begin
            if (!blink_en)   state_nxt = ST_STEADY;
            else if (pre_tc) state_nxt = ST_OFF;
         end
         ST_OFF: begin
            blink_on = 1'b0;
            if (!blink_en)   state_nxt = ST_STEADY;
            else if (pre_tc) state_nxt = ST_ON;
         end
         default: state_nxt = ST_STEADY;
      endcase
   end

   // Stage p0: lit pattern; lamp test overrides everything, then blank, then PWM/blink.
   always_comb begin
      lit_p0 = blank ? 7'h00 : (seg_sh & {7{pwm_on & blink_on}});
`ifdef HEX_SEG_LAMP_TEST_EN
      if (lamp_test) lit_p0 = 7'h7F;
`endif
   end

   // Stage p1: registered pin drive with polarity applied.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         hex_out <= SEG_OFF;
      else
         hex_out <= (ACTIVE_LOW != 0) ? ~lit_p0 : lit_p0;
   end

endmodule
